apb_master: RTL and testbench
=============================

# apb_master

APB4 requester that converts a single-outstanding command/response handshake into APB transfers. It drives the APB slave port of the UART peripheral (and any other APB slave in the subsystem) from a bench driver, a debug bridge or an on-chip controller. It adds a wait-state timeout so that a hung slave cannot stall the requester.

## Interface
Parameters:
- ADDR_WIDTH, 5, APB address width.
- DATA_WIDTH, 32, APB data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when valid and ready are both high.
- req_addr_i  in  ADDR_WIDTH  target address.
- req_write_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_strb_i  in  DATA_WIDTH/8  write byte strobes.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when valid and ready are both high.
- resp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- resp_slverr_o  out  1  pslverr sampled at completion, or 1 on timeout.
- resp_timeout_o  out  1  1 if the transfer was aborted by the timeout.
- psel_o, penable_o, pwrite_o  out  1  APB control.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  DATA_WIDTH/8  APB strobes.
- pready_i, pslverr_i  in  1  APB completion and error.
- prdata_i  in  DATA_WIDTH  APB read data.

## Operation
- States:
  - IDLE: the only state that accepts a command.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
  - RESP: resp_valid=1.
- IDLE behaviour: req_ready_o=1 in IDLE only, otherwise 0. On a command handshake, register address, write, wdata and strobes, then go to SETUP.
- Read strobes: pstrb_o is forced to 0 for reads, per APB4. pwdata_o holds the registered value.
- SETUP always lasts exactly 1 cycle, then ACCESS.
- ACCESS exit on pready_i=1:
  - capture prdata_i (reads only; writes capture 0) and pslverr_i;
  - resp_timeout_o=0;
  - go to RESP.
- ACCESS exit on timeout (TIMEOUT_CYCLES≠0, pready_i still 0 when the wait counter reaches TIMEOUT_CYCLES):
  - go to RESP with rdata=0, slverr=1, timeout=1;
  - a late pready_i is ignored.
- RESP: psel_o and penable_o are 0. Hold all response fields stable until resp_ready_i=1, then go to IDLE.
- Wait counter: width $clog2(TIMEOUT_CYCLES+1). Cleared on entering ACCESS, incremented each ACCESS cycle without pready_i. It saturates and never wraps.
- paddr_o, pwrite_o, pwdata_o and pstrb_o:
  - change only on command acceptance;
  - stay stable through SETUP and ACCESS;
  - keep their value in RESP and IDLE.
- Reset while rst_i=1:
  - next state is IDLE;
  - every registered output is 0: psel, penable, paddr, pwrite, pwdata, pstrb, resp_valid, resp_rdata, resp_slverr, resp_timeout;
  - the wait counter is 0.
- Reset during SETUP, ACCESS or RESP abandons the transfer: no response, and psel_o is 0 after the reset edge.

## Timing
- All APB and response outputs are registered. req_ready_o is decoded from state only, with no combinational path from req_valid_i.
- Handshake at edge N: SETUP during cycle N+1, ACCESS from N+2.
- pready_i high in the first ACCESS cycle: resp_valid_o high from N+3.
- Each APB wait state adds 1 cycle.
- Zero-wait throughput: one transfer per 4 cycles with resp_ready_i tied high (IDLE, SETUP, ACCESS, RESP).
- A timeout aborts after exactly TIMEOUT_CYCLES ACCESS cycles. RESP is entered on the following edge.
- req_valid_i outside IDLE is ignored; the command is held by the requester.

## Structure
- Shared package gets:
  - the state enum typedef `apb_master_state_e` (IDLE, SETUP, ACCESS, RESP);
  - a response struct `apb_master_resp_t` (rdata, slverr, timeout).
- Single flat module with no sub-module. The timeout counter is a small inline always_ff.

## Test plan
- Zero-wait write: addr 0x04, wdata 0xA5, strb 0x1 → psel high for 2 cycles, pstrb_o=0x1, resp one edge after ACCESS with slverr=0, rdata=0.
- Read with 3 wait states, prdata=0x1234_5678 → resp_rdata_o=0x12345678 valid 6 cycles after the handshake; paddr stable throughout ACCESS.
- pslverr_i=1 on completion of a read to 0x1C → resp_slverr_o=1, resp_timeout_o=0; pstrb_o=0 during the read.
- TIMEOUT_CYCLES=4, pready_i held low → penable drops after 4 ACCESS cycles, resp_slverr=1, resp_timeout=1, rdata=0; a later pready_i pulse has no effect.
- resp_ready_i low for 10 cycles → response fields constant, req_ready_o=0, a new req_valid_i is not accepted until the response is consumed.
- rst_i asserted for 1 cycle during ACCESS → psel_o=penable_o=resp_valid_o=0 next cycle, req_ready_o=1, no response emitted.

Source files
------------

// File: rtl/apb_master_pkg.sv
// apb_master shared types: FSM state encoding and the
// response bundle carried from ACCESS to the requester.
package apb_master_pkg;

  localparam int unsigned APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_master_state_e;

  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              slverr;
    logic              timeout;
  } apb_master_resp_t;

endpackage

// File: rtl/apb_master.sv
// APB4 requester: one outstanding command in, one APB
// transfer out, with a wait-state timeout against hung slaves.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = APB_DW,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_slverr_o,
  output logic                    resp_timeout_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  apb_master_state_e state_q, state_d;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic                  resp_valid_q, resp_valid_d;
  apb_master_resp_t      resp_q, resp_d;

  logic [CW-1:0] cnt_q;
  logic          timeout_hit;

  // Fires on the last allowed ACCESS cycle still without pready.
  assign timeout_hit = (TIMEOUT_CYCLES != 0)
                     && !pready_i
                     && (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    psel_d       = 1'b0;
    penable_d    = 1'b0;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    resp_valid_d = 1'b0;
    resp_d       = resp_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          paddr_d  = req_addr_i;
          pwrite_d = req_write_i;
          pwdata_d = req_wdata_i;
          pstrb_d  = req_write_i ? req_strb_i : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready_i) begin
          state_d        = RESP;
          resp_valid_d   = 1'b1;
          resp_d.rdata   = pwrite_q ? '0 : APB_DW'(prdata_i);
          resp_d.slverr  = pslverr_i;
          resp_d.timeout = 1'b0;
        end else if (timeout_hit) begin
          state_d        = RESP;
          resp_valid_d   = 1'b1;
          resp_d.rdata   = '0;
          resp_d.slverr  = 1'b1;
          resp_d.timeout = 1'b1;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
        else resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  // Wait counter: held at zero outside ACCESS, saturating inside.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ACCESS) begin
      cnt_q <= '0;
    end else if (!pready_i && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign psel_o         = psel_q;
  assign penable_o      = penable_q;
  assign pwrite_o       = pwrite_q;
  assign paddr_o        = paddr_q;
  assign pwdata_o       = pwdata_q;
  assign pstrb_o        = pstrb_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_rdata_o   = DATA_WIDTH'(resp_q.rdata);
  assign resp_slverr_o  = resp_q.slverr;
  assign resp_timeout_o = resp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level model checked every
// cycle, plus directed transfers with literal expectations.
module tb_apb_master;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_write_i;
  logic [DW-1:0] req_wdata_i;
  logic [SW-1:0] req_strb_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_slverr_o;
  logic          resp_timeout_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic          pready_i;
  logic          pslverr_i;
  logic [DW-1:0] prdata_i;

  always #5 clk_i = ~clk_i;

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_write_i   (req_write_i),
    .req_wdata_i   (req_wdata_i),
    .req_strb_i    (req_strb_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_rdata_o  (resp_rdata_o),
    .resp_slverr_o (resp_slverr_o),
    .resp_timeout_o(resp_timeout_o),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .pwrite_o      (pwrite_o),
    .paddr_o       (paddr_o),
    .pwdata_o      (pwdata_o),
    .pstrb_o       (pstrb_o),
    .pready_i      (pready_i),
    .pslverr_i     (pslverr_i),
    .prdata_i      (prdata_i)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Slave: pready after sl_wait ACCESS wait states (-1 = never).
  int            sl_wait  = 0;
  logic [DW-1:0] sl_rdata = '0;
  bit            sl_err   = 1'b0;
  bit            sl_pulse = 1'b0;
  int            acc_idx  = -1;

  initial begin
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = '0;
  end

  always @(posedge clk_i) begin
    #2;
    if (!penable_o) acc_idx = -1;
    else acc_idx++;
    pready_i = (penable_o && sl_wait >= 0 && acc_idx == sl_wait)
             || sl_pulse;
    pslverr_i = sl_err && pready_i;
    prdata_i  = sl_rdata;
  end

  // Model: a transfer is a count of cycles since its handshake;
  // cycle 1 is SETUP, cycles 2.. are ACCESS.
  bit            m_on   = 1'b0;
  bit            m_act  = 1'b0;
  bit            m_resp = 1'b0;
  int            m_cyc  = 0;
  logic [AW-1:0] e_addr;
  logic          e_write;
  logic [DW-1:0] e_wdata;
  logic [SW-1:0] e_strb;
  logic [DW-1:0] e_rdata;
  logic          e_err;
  logic          e_to;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_on = 1'b1; m_act = 1'b0; m_resp = 1'b0; m_cyc = 0;
      e_addr = '0; e_write = 1'b0; e_wdata = '0; e_strb = '0;
      e_rdata = '0; e_err = 1'b0; e_to = 1'b0;
    end else if (m_on) begin
      if (m_resp) begin
        if (resp_ready_i) m_resp = 1'b0;
      end else if (m_act) begin
        if (m_cyc >= 2 && pready_i) begin
          m_act = 1'b0; m_resp = 1'b1;
          e_rdata = e_write ? '0 : prdata_i;
          e_err = pslverr_i; e_to = 1'b0;
        end else if (m_cyc >= 2 && m_cyc - 1 == TO) begin
          m_act = 1'b0; m_resp = 1'b1;
          e_rdata = '0; e_err = 1'b1; e_to = 1'b1;
        end else begin
          m_cyc++;
        end
      end else if (req_valid_i) begin
        m_act = 1'b1; m_cyc = 1;
        e_addr = req_addr_i; e_write = req_write_i;
        e_wdata = req_wdata_i;
        e_strb = req_write_i ? req_strb_i : '0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_on) begin
      chk("psel", psel_o, m_act);
      chk("penable", penable_o, m_act && m_cyc >= 2);
      chk("req_ready", req_ready_o, !m_act && !m_resp);
      chk("resp_valid", resp_valid_o, m_resp);
      chk("paddr", paddr_o, e_addr);
      chk("pwrite", pwrite_o, e_write);
      chk("pwdata", pwdata_o, e_wdata);
      chk("pstrb", pstrb_o, e_strb);
      chk("resp_rdata", resp_rdata_o, e_rdata);
      chk("resp_slverr", resp_slverr_o, e_err);
      chk("resp_timeout", resp_timeout_o, e_to);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] d,
                        input logic [SW-1:0] s,
                        output bit ok);
    bit hs;
    ok = 1'b0;
    req_valid_i = 1'b1; req_addr_i = a; req_write_i = w;
    req_wdata_i = d; req_strb_i = s;
    for (int i = 0; i < 50; i++) begin
      hs = req_ready_o;
      tick();
      if (hs) begin ok = 1'b1; break; end
    end
    req_valid_i = 1'b0;
    if (!ok) chk("handshake_bound", 0, 1);
  endtask

  // Returns at the first cycle with resp_valid_o high.
  task automatic run_txn(input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d,
                         input logic [SW-1:0] s,
                         input int waits,
                         input logic [DW-1:0] rd, input bit err,
                         output int lat, output int np,
                         output int ne, output logic [SW-1:0] st);
    bit ok;
    bit got;
    sl_wait = waits; sl_rdata = rd; sl_err = err;
    lat = 0; np = 0; ne = 0; st = 'x; got = 1'b0;
    do_req(a, w, d, s, ok);
    if (ok) begin
      lat = 1;
      for (int i = 0; i < 40; i++) begin
        if (psel_o) begin np++; st = pstrb_o; end
        if (penable_o) ne++;
        if (resp_valid_o) begin got = 1'b1; break; end
        tick();
        lat++;
      end
      if (!got) chk("resp_bound", 0, 1);
    end
  endtask

  int            lat, np, ne;
  logic [SW-1:0] st;
  bit            ok;

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; resp_ready_i = 1'b1;
    req_addr_i = '0; req_write_i = 1'b0;
    req_wdata_i = '0; req_strb_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_psel", psel_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rdata", resp_rdata_o, 0);
    tick();

    // Zero-wait write.
    run_txn(5'h04, 1'b1, 32'hA5, 4'h1, 0, 32'hDEAD_BEEF, 0,
            lat, np, ne, st);
    chk("wr_lat", lat, 3);
    chk("wr_psel_cycles", np, 2);
    chk("wr_pen_cycles", ne, 1);
    chk("wr_pstrb", st, 4'h1);
    chk("wr_rdata", resp_rdata_o, 0);
    chk("wr_slverr", resp_slverr_o, 0);
    tick();

    // Read with three wait states.
    run_txn(5'h08, 1'b0, 32'h55, 4'hF, 3, 32'h1234_5678, 0,
            lat, np, ne, st);
    chk("rd3_lat", lat, 6);
    chk("rd3_pen_cycles", ne, 4);
    chk("rd3_rdata", resp_rdata_o, 32'h1234_5678);
    chk("rd3_pstrb", st, 0);
    tick();

    // Read with slave error.
    run_txn(5'h1C, 1'b0, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 1,
            lat, np, ne, st);
    chk("err_slverr", resp_slverr_o, 1);
    chk("err_timeout", resp_timeout_o, 0);
    chk("err_pstrb", st, 0);
    chk("err_rdata", resp_rdata_o, 32'hCAFE_F00D);
    tick();

    // Timeout with the response held back for 10 cycles.
    resp_ready_i = 1'b0;
    run_txn(5'h10, 1'b0, 32'h0, 4'h0, -1, 32'h1111_2222, 0,
            lat, np, ne, st);
    chk("to_lat", lat, 6);
    chk("to_pen_cycles", ne, TO);
    chk("to_rdata", resp_rdata_o, 0);
    chk("to_slverr", resp_slverr_o, 1);
    chk("to_timeout", resp_timeout_o, 1);
    req_valid_i = 1'b1; req_addr_i = 5'h0C; req_write_i = 1'b1;
    req_wdata_i = 32'h77; req_strb_i = 4'h3;
    for (int i = 0; i < 10; i++) begin
      sl_pulse = (i == 2);
      tick();
      chk("hold_valid", resp_valid_o, 1);
      chk("hold_req_ready", req_ready_o, 0);
      chk("hold_timeout", resp_timeout_o, 1);
      chk("hold_rdata", resp_rdata_o, 0);
    end
    sl_pulse = 1'b0;
    resp_ready_i = 1'b1;
    run_txn(5'h0C, 1'b1, 32'h77, 4'h3, 1, 32'h9999_9999, 0,
            lat, np, ne, st);
    chk("held_lat", lat, 4);
    chk("held_pstrb", st, 4'h3);
    chk("held_rdata", resp_rdata_o, 0);
    chk("held_timeout", resp_timeout_o, 0);
    tick();

    // Reset during ACCESS abandons the transfer.
    sl_wait = -1;
    do_req(5'h14, 1'b0, 32'h0, 4'h0, ok);
    tick();
    chk("ra_in_access", penable_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("ra_psel", psel_o, 0);
    chk("ra_penable", penable_o, 0);
    chk("ra_resp_valid", resp_valid_o, 0);
    chk("ra_req_ready", req_ready_o, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ra_no_resp", resp_valid_o, 0);
    end

    // Zero-wait read after reset.
    run_txn(5'h02, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_CAFE, 0,
            lat, np, ne, st);
    chk("rd0_lat", lat, 3);
    chk("rd0_rdata", resp_rdata_o, 32'h0BAD_CAFE);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
